// File: rtl/line_setup.sv
// Line setup: two-stage pipeline turning clipped endpoints into packed 69-bit line words.
// Optional LINE_SETUP_DROP_INVALID_EN consumes invalid lines at S2 instead of writing them.
module line_setup #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_x0,
  input  logic [9:0]  in_y0,
  input  logic [9:0]  in_x1,
  input  logic [9:0]  in_y1,
  input  logic [2:0]  in_color,
  input  logic        in_accept,
  input  logic        eoo_in,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [68:0] fifo_data,
  output logic        end_of_objects
);

  localparam logic [10:0] W_LIMIT = 11'(SCREEN_W);
  localparam logic [10:0] H_LIMIT = 11'(SCREEN_H);

  logic        r_s1_valid;
  logic [9:0]  r_s1_x0;
  logic [9:0]  r_s1_y0;
  logic [9:0]  r_s1_x1;
  logic [9:0]  r_s1_y1;
  logic [2:0]  r_s1_color;
  logic        r_s1_accept;
  logic [10:0] r_s1_dx;
  logic [10:0] r_s1_dy;

  logic        r_s2_valid;
  logic [68:0] r_s2_word;
  logic        r_eoo;

  logic        w_advance;
  logic        w_transfer;
  logic        w_s2_drop;
  logic [10:0] w_in_dx;
  logic [10:0] w_in_dy;
  logic [10:0] w_adx;
  logic [10:0] w_ady;
  logic [2:0]  w_octant;
  logic        w_line_ok;
  logic [68:0] w_word;

`ifdef LINE_SETUP_DROP_INVALID_EN
  assign w_s2_drop = r_s2_valid & ~r_s2_word[3];
`else
  assign w_s2_drop = 1'b0;
`endif

  assign w_advance  = ~r_s2_valid | ~fifo_full | w_s2_drop;
  assign in_ready   = (~r_s1_valid | w_advance) & ~flush;
  assign w_transfer = in_valid & in_ready;
  assign fifo_wr_en = r_s2_valid & ~fifo_full & ~w_s2_drop;
  assign fifo_data  = r_s2_word;

  // Endpoints are zero-extended so the 11-bit difference never overflows.
  assign w_in_dx = {1'b0, in_x1} - {1'b0, in_x0};
  assign w_in_dy = {1'b0, in_y1} - {1'b0, in_y0};

  assign w_adx = r_s1_dx[10] ? (11'd0 - r_s1_dx) : r_s1_dx;
  assign w_ady = r_s1_dy[10] ? (11'd0 - r_s1_dy) : r_s1_dy;

  assign w_octant  = {(w_ady > w_adx), r_s1_dx[10], r_s1_dy[10]};
  assign w_line_ok = r_s1_accept &
                     ({1'b0, r_s1_x0} < W_LIMIT) & ({1'b0, r_s1_x1} < W_LIMIT) &
                     ({1'b0, r_s1_y0} < H_LIMIT) & ({1'b0, r_s1_y1} < H_LIMIT);

  assign w_word = {r_s1_x0, r_s1_y0, r_s1_x1, r_s1_y1,
                   r_s1_dy, r_s1_dx, r_s1_color, w_line_ok, w_octant};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_x0     <= '0;
      r_s1_y0     <= '0;
      r_s1_x1     <= '0;
      r_s1_y1     <= '0;
      r_s1_color  <= '0;
      r_s1_accept <= 1'b0;
      r_s1_dx     <= '0;
      r_s1_dy     <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (w_transfer) begin
        r_s1_x0     <= in_x0;
        r_s1_y0     <= in_y0;
        r_s1_x1     <= in_x1;
        r_s1_y1     <= in_y1;
        r_s1_color  <= in_color;
        r_s1_accept <= in_accept;
        r_s1_dx     <= w_in_dx;
        r_s1_dy     <= w_in_dy;
      end
    end
  end

  // A write coinciding with flush still lands; only the valid bit is cleared afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_word  <= '0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_word <= w_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_eoo <= 1'b0;
    end else if (flush) begin
      r_eoo <= 1'b0;
    end else begin
      r_eoo <= eoo_in & ~r_s1_valid & ~r_s2_valid & ~w_transfer;
    end
  end

  assign end_of_objects = r_eoo;

endmodule
